// File: rtl/block_loader_if.sv
// Bundle of the tile-fetch control, row-read memory port and committed tile bus
// shared by block_loader and whatever drives it.
interface block_loader_if #(
    parameter int BLOCK_BITS = 3,
    parameter int WORD_BITS  = 16,
    parameter int ADDR_BITS  = 16
);
    localparam int BLOCK_WIDTH = 2 ** BLOCK_BITS;
    localparam int ROW_N       = WORD_BITS * BLOCK_WIDTH;
    localparam int BUS_N       = WORD_BITS * BLOCK_WIDTH * BLOCK_WIDTH - 1;

    logic                 start;
    logic [ADDR_BITS-1:0] base_addr;
    logic                 busy;
    logic                 done;
    logic                 block_valid;
    logic                 mem_rd;
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_ready;
    logic                 mem_rvalid;
    logic [ROW_N-1:0]     mem_rdata;
    logic [BUS_N:0]       data_out;

    modport master (
        output start, base_addr, mem_ready, mem_rvalid, mem_rdata,
        input  busy, done, block_valid, mem_rd, mem_addr, data_out
    );

    modport slave (
        input  start, base_addr, mem_ready, mem_rvalid, mem_rdata,
        output busy, done, block_valid, mem_rd, mem_addr, data_out
    );
endinterface

// File: rtl/block_loader.sv
// Fetches a square tile row by row into a shadow buffer, then commits the whole
// tile to data_out in one cycle so downstream logic only ever sees complete tiles.
module block_loader #(
    parameter int BLOCK_BITS = 3,
    parameter int WORD_BITS  = 16,
    parameter int ADDR_BITS  = 16,
    parameter int ROW_STRIDE = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    block_loader_if.slave bus
);
    localparam int BLOCK_WIDTH = 2 ** BLOCK_BITS;
    localparam int ROW_N       = WORD_BITS * BLOCK_WIDTH;
    localparam int BUS_N       = WORD_BITS * BLOCK_WIDTH * BLOCK_WIDTH - 1;

    localparam logic [BLOCK_BITS:0]  CNT_FULL = {1'b1, {BLOCK_BITS{1'b0}}};
    localparam logic [BLOCK_BITS:0]  CNT_LAST = CNT_FULL - 1'b1;
    localparam logic [ADDR_BITS-1:0] STRIDE   = ADDR_BITS'(ROW_STRIDE);

    typedef enum logic [1:0] {IDLE, FETCH, COMMIT} state_t;

    state_t               state_reg, state_next;
    logic [BLOCK_BITS:0]  issue_cnt_reg, ret_cnt_reg;
    logic [ADDR_BITS-1:0] base_reg;
    logic [ROW_N-1:0]     shadow_reg [BLOCK_WIDTH];
    logic [BUS_N:0]       shadow_flat;
    logic [BUS_N:0]       data_out_reg;
    logic                 block_valid_reg, done_reg;
    logic                 issue_ok, ret_ok, last_ret;

    // Counters carry one extra bit so "all rows issued/returned" is representable.
    assign issue_ok = (state_reg == FETCH) && (issue_cnt_reg < CNT_FULL);
    assign ret_ok   = (state_reg == FETCH) && bus.mem_rvalid && (ret_cnt_reg < CNT_FULL);
    assign last_ret = ret_ok && (ret_cnt_reg == CNT_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = FETCH;
            FETCH:   if (last_ret)  state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            issue_cnt_reg   <= '0;
            ret_cnt_reg     <= '0;
            base_reg        <= '0;
            data_out_reg    <= '0;
            block_valid_reg <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == COMMIT);
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        base_reg      <= bus.base_addr;
                        issue_cnt_reg <= '0;
                        ret_cnt_reg   <= '0;
                    end
                end
                FETCH: begin
                    if (issue_ok && bus.mem_ready) issue_cnt_reg <= issue_cnt_reg + 1'b1;
                    if (ret_ok)                    ret_cnt_reg   <= ret_cnt_reg + 1'b1;
                end
                COMMIT: begin
                    data_out_reg    <= shadow_flat;
                    block_valid_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // One register per tile row; row 0 occupies the MSBs of the flattened tile.
    generate
        for (genvar gi = 0; gi < BLOCK_WIDTH; gi++) begin : g_row
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_reg[gi] <= '0;
                end else if (ret_ok && (ret_cnt_reg[BLOCK_BITS-1:0] == BLOCK_BITS'(gi))) begin
                    shadow_reg[gi] <= bus.mem_rdata;
                end
            end
            assign shadow_flat[BUS_N - gi*ROW_N -: ROW_N] = shadow_reg[gi];
        end
    endgenerate

    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = done_reg;
    assign bus.block_valid = block_valid_reg;
    assign bus.data_out    = data_out_reg;
    assign bus.mem_rd      = issue_ok;
    assign bus.mem_addr    = base_reg + ADDR_BITS'(issue_cnt_reg) * STRIDE;
endmodule

// File: tb/tb_block_loader.sv
// Randomized scoreboard bench for block_loader: a behavioural row memory, an
// expected-address queue and an expected-tile queue checked by a separate monitor.
module tb_block_loader;
    localparam int BW     = 8;
    localparam int WB     = 16;
    localparam int STRIDE = 8;
    localparam int ROW_N  = WB * BW;
    localparam int BUS_W  = WB * BW * BW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    block_loader_if #(.BLOCK_BITS(3), .WORD_BITS(WB), .ADDR_BITS(16)) bus ();
    block_loader #(.BLOCK_BITS(3), .WORD_BITS(WB), .ADDR_BITS(16), .ROW_STRIDE(STRIDE))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {logic [15:0] addr; int due;} pend_t;

    int n_vec = 0, n_err = 0, cyc = 0;
    pend_t            pend_q[$];
    logic [15:0]      exp_addr_q[$];
    logic [BUS_W-1:0] exp_tile_q[$];
    logic [BUS_W-1:0] model_out = '0;
    logic             model_valid = 1'b0;
    int   cmode = 0, rdy_mode = 0, gap_max = 0;
    bit   stray_en = 0;
    logic [15:0] cur_base = '0;
    logic [31:0] salt = '0;
    int   done_cnt = 0, done_cyc = 0, rd_cnt = 0, ret_seen = 0, start_cyc = 0;
    logic hold_pending = 1'b0;
    logic [15:0] hold_addr = '0;

    // Memory contents: mode 0 gives word {row, col}; mode 1 an address hash.
    function automatic logic [ROW_N-1:0] row_content(input logic [15:0] addr);
        logic [ROW_N-1:0] r;
        logic [15:0] rowi, w;
        rowi = (addr - cur_base) / 16'(STRIDE);
        for (int i = 0; i < BW; i++) begin
            if (cmode == 0) w = {rowi[7:0], 8'(i)};
            else            w = (addr * 16'd31) ^ 16'(i * 7 + 1) ^ salt[15:0];
            r[ROW_N-1-i*WB -: WB] = w;
        end
        return r;
    endfunction

    function automatic logic [BUS_W-1:0] ref_tile(input logic [15:0] base);
        logic [BUS_W-1:0] t;
        for (int j = 0; j < BW; j++)
            t[BUS_W-1-j*ROW_N -: ROW_N] = row_content(base + 16'(j * STRIDE));
        return t;
    endfunction

    task automatic report_tile(input string tag, input logic [BUS_W-1:0] got,
                               input logic [BUS_W-1:0] exp);
        int row;
        row = 0;
        for (int j = BW - 1; j >= 0; j--)
            if (got[BUS_W-1-j*ROW_N -: ROW_N] !== exp[BUS_W-1-j*ROW_N -: ROW_N]) row = j;
        n_err++;
        $display("FAIL %s: row %0d got %h expected %h", tag, row,
                 got[BUS_W-1-row*ROW_N -: ROW_N], exp[BUS_W-1-row*ROW_N -: ROW_N]);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: returns rows in request order after 1 + random gap cycles.
    initial begin
        pend_t p;
        logic [15:0] ea;
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = row_content(pend_q[0].addr);
                void'(pend_q.pop_front());
                ret_seen++;
            end else if (stray_en && !bus.busy && $urandom_range(0, 1) == 1) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = {4{$urandom()}};
            end else begin
                bus.mem_rvalid = 1'b0;
            end
            case (rdy_mode)
                0:       bus.mem_ready = 1'b1;
                1:       bus.mem_ready = (cyc % 2 == 0);
                default: bus.mem_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (rst_n && bus.mem_rd) begin
                if (hold_pending) check("addr_hold", 32'(bus.mem_addr), 32'(hold_addr));
                if (bus.mem_ready) begin
                    hold_pending = 1'b0;
                    rd_cnt++;
                    n_vec++;
                    if (exp_addr_q.size() == 0) begin
                        n_err++;
                        $display("FAIL extra_read: got addr %h expected no read", bus.mem_addr);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        if (bus.mem_addr !== ea) begin
                            n_err++;
                            $display("FAIL mem_addr: got %h expected %h", bus.mem_addr, ea);
                        end
                    end
                    p.addr = bus.mem_addr;
                    p.due  = cyc + 1 + int'($urandom_range(0, gap_max));
                    pend_q.push_back(p);
                end else begin
                    hold_pending = 1'b1;
                    hold_addr    = bus.mem_addr;
                end
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    // Monitor: every done pops one expected tile; otherwise data_out must hold.
    initial begin
        logic [BUS_W-1:0] t;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                n_vec++;
                if (bus.done === 1'b1) begin
                    done_cnt++;
                    done_cyc = cyc;
                    if (exp_tile_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_done: got done=1 expected 0");
                    end else begin
                        t = exp_tile_q.pop_front();
                        model_out   = t;
                        model_valid = 1'b1;
                        if (bus.data_out !== t) report_tile("commit_tile", bus.data_out, t);
                        if (bus.block_valid !== 1'b1) begin
                            n_err++;
                            $display("FAIL commit_valid: got %b expected 1", bus.block_valid);
                        end
                    end
                end else begin
                    if (bus.data_out !== model_out) report_tile("tile_hold", bus.data_out, model_out);
                    if (bus.block_valid !== model_valid) begin
                        n_err++;
                        $display("FAIL valid_hold: got %b expected %b", bus.block_valid, model_valid);
                    end
                end
            end
        end
    end

    // Called at negedge+2; accepted starts register their expectations.
    task automatic start_fetch(input logic [15:0] base);
        bus.start = 1'b1;
        bus.base_addr = base;
        if (!bus.busy) begin
            cur_base = base;
            for (int j = 0; j < BW; j++) exp_addr_q.push_back(base + 16'(j * STRIDE));
            exp_tile_q.push_back(ref_tile(base));
            start_cyc = cyc;
        end
        @(negedge clk); #2;
        bus.start = 1'b0;
    endtask

    task automatic pulse_ignored_start(input logic [15:0] base);
        check("busy_when_ignored", 32'(bus.busy), 32'd1);
        bus.start = 1'b1;
        bus.base_addr = base;
        @(negedge clk); #2;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge clk); #2;
            k++;
        end
        check("done_timeout", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  32'(bus.busy), 32'd0);
        check({tag, "_done"},  32'(bus.done), 32'd0);
        check({tag, "_valid"}, 32'(bus.block_valid), 32'd0);
        check({tag, "_rd"},    32'(bus.mem_rd), 32'd0);
        check({tag, "_addr"},  32'(bus.mem_addr), 32'd0);
        check({tag, "_data"},  32'(bus.data_out != '0), 32'd0);
    endtask

    initial begin
        logic [BUS_W-1:0] tile1;
        int tgt, rd0, r0, k;
        bus.start = 1'b0;
        bus.base_addr = '0;
        repeat (3) @(negedge clk);
        #2;
        check_zero("reset");
        #1 rst_n = 1'b1;
        @(negedge clk); #2;

        // 1) basic fetch, latency and word placement
        cmode = 0; rdy_mode = 0; gap_max = 0;
        tgt = done_cnt + 1; rd0 = rd_cnt;
        start_fetch(16'h0100);
        wait_done(tgt, 200);
        check("t1_latency", 32'(done_cyc - start_cyc), 32'd11);
        tile1 = bus.data_out;
        check("t1_word_3_5", 32'(tile1[BUS_W-1-(8*3+5)*WB -: WB]), 32'h0305);
        check("t1_valid", 32'(bus.block_valid), 32'd1);
        check("t1_reads", 32'(rd_cnt - rd0), 32'd8);
        @(negedge clk); #2;
        check("t1_done_pulse", 32'(bus.done), 32'd0);

        // 2) toggling mem_ready
        rdy_mode = 1;
        tgt = done_cnt + 1; rd0 = rd_cnt;
        start_fetch(16'h0100);
        wait_done(tgt, 300);
        check("t2_reads", 32'(rd_cnt - rd0), 32'd8);
        n_vec++;
        if (bus.data_out !== tile1) report_tile("t2_same_tile", bus.data_out, tile1);

        // 3) random return gaps with random ready
        cmode = 1; salt = $urandom(); rdy_mode = 2; gap_max = 4;
        tgt = done_cnt + 1; rd0 = rd_cnt;
        start_fetch(16'($urandom()));
        wait_done(tgt, 500);
        repeat (6) @(negedge clk);
        #2;
        check("t3_single_done", 32'(done_cnt), 32'(tgt));
        check("t3_reads", 32'(rd_cnt - rd0), 32'd8);

        // 4) starts during fetch and stray beats while idle
        rdy_mode = 0; gap_max = 0; stray_en = 1;
        repeat (6) @(negedge clk);
        #2;
        tgt = done_cnt + 1; rd0 = rd_cnt;
        start_fetch(16'h1234);
        @(negedge clk); #2;
        pulse_ignored_start(16'h4000);
        repeat (5) @(negedge clk);
        #2;
        pulse_ignored_start(16'h5000);
        wait_done(tgt, 200);
        repeat (8) @(negedge clk);
        #2;
        stray_en = 0;
        check("t4_reads", 32'(rd_cnt - rd0), 32'd8);
        check("t4_single_done", 32'(done_cnt), 32'(tgt));

        // 5) address wrap and back-to-back start in the done cycle
        cmode = 0;
        tgt = done_cnt + 1;
        start_fetch(16'hFFF8);
        wait_done(tgt, 200);
        check("t5_done_now", 32'(bus.done), 32'd1);
        check("t5_idle_in_done", 32'(bus.busy), 32'd0);
        tgt = done_cnt + 1;
        start_fetch(16'h0040);
        check("t5_b2b_busy", 32'(bus.busy), 32'd1);
        wait_done(tgt, 200);

        // 6) asynchronous reset after four returns
        cmode = 1; salt = $urandom();
        r0 = ret_seen;
        start_fetch(16'h0200);
        k = 0;
        while (ret_seen < r0 + 4 && k < 100) begin
            @(posedge clk);
            k++;
        end
        check("t6_reached_4_returns", 32'(ret_seen >= r0 + 4), 32'd1);
        #2;
        rst_n = 1'b0;
        pend_q.delete(); exp_addr_q.delete(); exp_tile_q.delete();
        model_out = '0; model_valid = 1'b0; hold_pending = 1'b0;
        #1;
        check_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk); #2;
        tgt = done_cnt + 1;
        start_fetch(16'h0300);
        wait_done(tgt, 200);

        // random fetches
        for (int n = 0; n < 4; n++) begin
            cmode = int'($urandom_range(0, 1)); salt = $urandom();
            rdy_mode = int'($urandom_range(0, 2)); gap_max = int'($urandom_range(0, 3));
            tgt = done_cnt + 1; rd0 = rd_cnt;
            start_fetch(16'($urandom()));
            wait_done(tgt, 500);
            check("rand_reads", 32'(rd_cnt - rd0), 32'd8);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
